// File: rtl/prbg_pkg.sv
// Types and widths shared between the PRBG top and its detection logger.
package prbg_pkg;

    localparam int WIN_W     = 3;
    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 16;
    localparam int DEPTH_DEF = 8;
    localparam int ENTRY_W   = TS_W_DEF + WIN_W;

    typedef struct packed {
        logic [TS_W_DEF-1:0] ts;
        logic [WIN_W-1:0]    bits;
    } log_entry_t;

    function automatic int entry_width(input int ts_w);
        return ts_w + WIN_W;
    endfunction

endpackage

// File: rtl/prbg_log_fifo.sv
// Synchronous DEPTH x W FIFO; registered write, combinational head read.
// Pushes while full are accepted only when a pop frees the slot in the same cycle.
module prbg_log_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 19
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wr_dat,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the level counter alone says what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_dat;
    end

    assign rd_dat = mem_q[rd_ptr_q];
    assign level  = level_q;

endmodule

// File: rtl/detect_event_logger.sv
// Timestamps PRBG detections into a FIFO drained by valid/ready; keeps saturating hit stats.
// Optional DROP_COUNT_EN adds a saturating count of pushes lost to a full FIFO.
module detect_event_logger
    import prbg_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     enable,
    input  logic                     clr_stats,
    input  logic                     detect_in,
    input  logic [WIN_W-1:0]         bits_in,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [TS_W-1:0]          rd_ts,
    output logic [WIN_W-1:0]         rd_bits,
    output logic [$clog2(DEPTH):0]   fifo_level,
`ifdef DROP_COUNT_EN
    output logic [CNT_W-1:0]         drop_count,
`endif
    output logic [CNT_W-1:0]         hit_count,
    output logic                     overflow
);

    localparam int EW = entry_width(TS_W);

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [WIN_W-1:0] bits;
    } entry_t;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic             ovf_q, ovf_d;
    logic             det, pop, drop, fifo_full, fifo_empty;
    logic [EW-1:0]    fifo_rd_dat;
    entry_t           wr_entry, head;

    assign det      = detect_in & enable;
    assign pop      = rd_valid & rd_ready;
    // A full FIFO still takes the push if the head leaves in the same cycle.
    assign drop     = det & fifo_full & ~pop;
    assign wr_entry = '{ts: ts_q, bits: bits_in};

    always_comb begin
        ts_d  = enable ? ts_q + TS_W'(1) : ts_q;
        hit_d = clr_stats ? '0 : hit_q;
        if (det && hit_d != '1) hit_d = hit_d + CNT_W'(1);
        ovf_d = (clr_stats ? 1'b0 : ovf_q) | drop;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            ts_q  <= '0;
            hit_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ts_q  <= ts_d;
            hit_q <= hit_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef DROP_COUNT_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = clr_stats ? '0 : drop_cnt_q;
        if (drop && drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (res) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`endif

    prbg_log_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk    (clk),
        .res    (res),
        .push   (det),
        .pop    (pop),
        .wr_dat (wr_entry),
        .rd_dat (fifo_rd_dat),
        .level  (fifo_level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign head      = entry_t'(fifo_rd_dat);
    assign rd_valid  = ~fifo_empty;
    assign rd_ts     = fifo_empty ? '0 : head.ts;
    assign rd_bits   = fifo_empty ? '0 : head.bits;
    assign hit_count = hit_q;
    assign overflow  = ovf_q;

endmodule
